id_ex_stage_reg: RTL
====================

# id_ex_stage_reg

ID/EX pipeline register of the MIPS core. It captures decoded operands, immediate, shamt, PC and control bits from ID and presents them to EX. In the same edge it computes the registered forwarding selects (`o_corto_cir_regA`/`o_corto_cir_regB`) that drive the EX operand muxes. `o_rdata_a` and `o_rdata_b` are those muxes' ID/EX-register inputs. Supports load-use bubble insertion, branch flush and a debug-unit pipeline freeze.

## Interface
Parameters:
- `NBITS`, 32, data/PC/immediate width
- `CORTOCIRCUITO`, 3, forwarding-select width
- `REGS`, 5, register-index width
- `CTRL_W`, 10, control-bundle width

Ports:
- `i_clk`  in  1  clock, rising edge
- `i_reset`  in  1  reset; asynchronous, active-high (fixed)
- `i_enable`  in  1  debug-unit step/run enable; 0 = freeze
- `i_stall`  in  1  load-use hazard; insert bubble
- `i_flush`  in  1  taken branch/jump; insert bubble
- `i_rs`, `i_rt`, `i_rd`  in  REGS each  register fields from ID
- `i_shamt`  in  5  shift amount
- `i_rdata_a`, `i_rdata_b`  in  NBITS each  register-file read data
- `i_imm`  in  NBITS  sign-extended immediate
- `i_pc`  in  NBITS  PC+4 of the ID instruction
- `i_ctrl`  in  CTRL_W  decoded control bundle
- `i_ex_mem_regwrite`  in  1  EX/MEM RegWrite
- `i_ex_mem_dst`  in  REGS  EX/MEM destination register
- `o_rdata_a`, `o_rdata_b`, `o_imm`, `o_pc`  out  NBITS each  registered copies of the inputs
- `o_shamt`  out  5  registered copy
- `o_rs`, `o_rt`  out  REGS each  registered copies
- `o_dst`  out  REGS  registered destination: `CTRL_REGDST ? rd : rt`
- `o_ctrl`  out  CTRL_W  registered control
- `o_corto_cir_regA`, `o_corto_cir_regB`  out  CORTOCIRCUITO each  forwarding selects
- `o_valid`  out  1  1 = real instruction, 0 = bubble

## Operation
- Priority per edge: reset > `!i_enable` (hold all state) > `i_flush` or `i_stall` (bubble) > load.
- Bubble:
  - `o_ctrl`=0, `o_valid`=0, `o_dst`=0, both selects = 3'b000.
  - Data fields load normally; they are don't-care.
  - A bubble never forwards and never writes.
- Load: all fields are registered from the inputs and `o_valid`=1.
- Forwarding select for source `s` (`i_rs` → A, `i_rt` → B):
  - 3'b001 (from EX/MEM): `s != 0` and current `o_ctrl[CTRL_REGWRITE]` and `s == o_dst`. The instruction now in EX moves to MEM on this edge.
  - 3'b010 (from MEM/WB): else if `s != 0` and `i_ex_mem_regwrite` and `s == i_ex_mem_dst`.
  - 3'b000 otherwise, which selects the ID/EX value.
  - 001 has priority over 010, so the youngest producer wins.
- Load-use correctness depends on the hazard unit asserting `i_stall`. This block does not detect load-use itself.
- Writeback in the same cycle as an ID read is resolved by the register file (write first half-cycle). It is not handled here.
- The B select is computed regardless of `CTRL_ALUSRC`. EX ignores it when the immediate is used.

## Timing
- Latency 1 cycle, ID inputs → outputs.
- The selects are valid in the same cycle as the registered data. The EX mux stays purely combinational.
- Reset (async assert, sync release): every output is 0, `o_valid`=0, selects 3'b000.
- Reset mid-operation discards the in-flight instruction.
- Freeze (`i_enable`=0): outputs stay stable for any number of cycles. Flush and stall are ignored while frozen.
- Stall and flush together produce a single bubble.
- The selects are recomputed after every bubble against the then-current `o_dst`. A stall therefore yields correct selects on re-issue.

## Structure
- Shared package `mips_pkg` holds:
  - control bit positions: `CTRL_REGWRITE`=0, `CTRL_MEMREAD`=1, `CTRL_MEMWRITE`=2, `CTRL_MEMTOREG`=3, `CTRL_ALUSRC`=4, `CTRL_REGDST`=5, `CTRL_ALUOP`=9:6
  - `CTRL_W`
  - select encodings `FWD_IDEX`=3'b000, `FWD_EXMEM`=3'b001, `FWD_MEMWB`=3'b010
- One combinational sub-module, `fwd_select`, instantiated twice (A and B). Inputs: source index, EX-stage RegWrite/dst, MEM-stage RegWrite/dst. Output: select.

## Test plan
- Reset asserted mid-stream, then released → all outputs 0, `o_valid`=0, selects 000. The first load afterwards shows `i_rdata_a`=0x1234 on `o_rdata_a` one cycle later.
- `add $3,$1,$2` then `sub $5,$3,$4` back-to-back → on `sub`'s cycle `o_corto_cir_regA`=001, B=000.
- `add $3,...`, nop, `or $6,$7,$3` → on `or`'s cycle B=010 (`i_ex_mem_dst`=3, `i_ex_mem_regwrite`=1).
- Producer writes `$0`, consumer reads `$0` → both selects 000. Two producers of `$3` in EX and MEM → select 001.
- `i_stall`=1 for one cycle with `lw $2` in EX → bubble (`o_ctrl`=0, `o_valid`=0). Next cycle the dependent `add` re-issues with select 010.
- `i_enable`=0 for 3 cycles with `i_flush` pulsed → outputs unchanged. With `i_enable`=1 and `i_flush`=1 → bubble; selects 000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: control-bundle bit positions and
// forwarding-select encodings used by the ID/EX register and EX muxes.
package mips_pkg;

    localparam int CTRL_W        = 10;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_ALUOP_LO = 6;
    localparam int CTRL_ALUOP_HI = 9;

    localparam logic [2:0] FWD_IDEX  = 3'b000;
    localparam logic [2:0] FWD_EXMEM = 3'b001;
    localparam logic [2:0] FWD_MEMWB = 3'b010;

endpackage

// File: rtl/id_ex_stage_reg_fwd_select.sv
// Forwarding select for one EX operand; the producer now in EX wins
// over the one in MEM, and $0 is never forwarded.
module fwd_select
    import mips_pkg::*;
#(
    parameter int REGS          = 5,
    parameter int CORTOCIRCUITO = 3
) (
    input  logic [REGS-1:0]          i_src,
    input  logic                     i_ex_regwrite,
    input  logic [REGS-1:0]          i_ex_dst,
    input  logic                     i_mem_regwrite,
    input  logic [REGS-1:0]          i_mem_dst,
    output logic [CORTOCIRCUITO-1:0] o_sel
);

    always_comb begin
        o_sel = CORTOCIRCUITO'(FWD_IDEX);
        if (i_src != '0) begin
            if (i_ex_regwrite && (i_src == i_ex_dst))
                o_sel = CORTOCIRCUITO'(FWD_EXMEM);
            else if (i_mem_regwrite && (i_src == i_mem_dst))
                o_sel = CORTOCIRCUITO'(FWD_MEMWB);
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with registered forwarding selects, bubble
// insertion on stall/flush and a debug freeze.
module id_ex_stage_reg #(
    parameter int NBITS         = 32,
    parameter int CORTOCIRCUITO = 3,
    parameter int REGS          = 5,
    parameter int CTRL_W        = mips_pkg::CTRL_W
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_stall,
    input  logic                     i_flush,
    input  logic [REGS-1:0]          i_rs,
    input  logic [REGS-1:0]          i_rt,
    input  logic [REGS-1:0]          i_rd,
    input  logic [4:0]               i_shamt,
    input  logic [NBITS-1:0]         i_rdata_a,
    input  logic [NBITS-1:0]         i_rdata_b,
    input  logic [NBITS-1:0]         i_imm,
    input  logic [NBITS-1:0]         i_pc,
    input  logic [CTRL_W-1:0]        i_ctrl,
    input  logic                     i_ex_mem_regwrite,
    input  logic [REGS-1:0]          i_ex_mem_dst,
    output logic [NBITS-1:0]         o_rdata_a,
    output logic [NBITS-1:0]         o_rdata_b,
    output logic [NBITS-1:0]         o_imm,
    output logic [NBITS-1:0]         o_pc,
    output logic [4:0]               o_shamt,
    output logic [REGS-1:0]          o_rs,
    output logic [REGS-1:0]          o_rt,
    output logic [REGS-1:0]          o_dst,
    output logic [CTRL_W-1:0]        o_ctrl,
    output logic [CORTOCIRCUITO-1:0] o_corto_cir_regA,
    output logic [CORTOCIRCUITO-1:0] o_corto_cir_regB,
    output logic                     o_valid
);

    logic [NBITS-1:0]         r_rdata_a, r_rdata_b, r_imm, r_pc;
    logic [4:0]               r_shamt;
    logic [REGS-1:0]          r_rs, r_rt, r_dst;
    logic [CTRL_W-1:0]        r_ctrl;
    logic [CORTOCIRCUITO-1:0] r_sel_a, r_sel_b;
    logic                     r_valid;

    logic [REGS-1:0]          w_dst;
    logic [CORTOCIRCUITO-1:0] w_sel_a, w_sel_b;
    logic                     w_bubble;

    assign w_dst    = i_ctrl[mips_pkg::CTRL_REGDST] ? i_rd : i_rt;
    assign w_bubble = i_flush | i_stall;

    // The instruction currently held here is the one entering MEM on this edge.
    fwd_select #(.REGS(REGS), .CORTOCIRCUITO(CORTOCIRCUITO)) u_fwd_a (
        .i_src          (i_rs),
        .i_ex_regwrite  (r_ctrl[mips_pkg::CTRL_REGWRITE]),
        .i_ex_dst       (r_dst),
        .i_mem_regwrite (i_ex_mem_regwrite),
        .i_mem_dst      (i_ex_mem_dst),
        .o_sel          (w_sel_a)
    );

    fwd_select #(.REGS(REGS), .CORTOCIRCUITO(CORTOCIRCUITO)) u_fwd_b (
        .i_src          (i_rt),
        .i_ex_regwrite  (r_ctrl[mips_pkg::CTRL_REGWRITE]),
        .i_ex_dst       (r_dst),
        .i_mem_regwrite (i_ex_mem_regwrite),
        .i_mem_dst      (i_ex_mem_dst),
        .o_sel          (w_sel_b)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
            r_shamt   <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dst     <= '0;
            r_ctrl    <= '0;
            r_sel_a   <= '0;
            r_sel_b   <= '0;
            r_valid   <= 1'b0;
        end else if (i_enable) begin
            r_rdata_a <= i_rdata_a;
            r_rdata_b <= i_rdata_b;
            r_imm     <= i_imm;
            r_pc      <= i_pc;
            r_shamt   <= i_shamt;
            r_rs      <= i_rs;
            r_rt      <= i_rt;
            // A bubble carries no control, so it can neither write nor forward.
            if (w_bubble) begin
                r_dst   <= '0;
                r_ctrl  <= '0;
                r_sel_a <= '0;
                r_sel_b <= '0;
                r_valid <= 1'b0;
            end else begin
                r_dst   <= w_dst;
                r_ctrl  <= i_ctrl;
                r_sel_a <= w_sel_a;
                r_sel_b <= w_sel_b;
                r_valid <= 1'b1;
            end
        end
    end

    assign o_rdata_a        = r_rdata_a;
    assign o_rdata_b        = r_rdata_b;
    assign o_imm            = r_imm;
    assign o_pc             = r_pc;
    assign o_shamt          = r_shamt;
    assign o_rs             = r_rs;
    assign o_rt             = r_rt;
    assign o_dst            = r_dst;
    assign o_ctrl           = r_ctrl;
    assign o_corto_cir_regA = r_sel_a;
    assign o_corto_cir_regB = r_sel_b;
    assign o_valid          = r_valid;

endmodule
